// File: rtl/axil_reg_responder_if.sv
// axil_reg_responder_if: AXI4-Lite bus bundle; master drives AW/W/AR/BREADY/RREADY, slave drives the rest.
interface axil_reg_responder_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]              S_AXI_AWPROT;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]              S_AXI_ARPROT;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;
  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axil_reg_responder.sv
// axil_reg_responder: AXI4-Lite register bank (S_AXI_ACLK/S_AXI_ARESET, s_axi slave bus, reg_q flat words, wr_pulse commit strobes); AXIL_REG_RESPONDER_SLVERR_EN makes out-of-range accesses SLVERR instead of aliasing.
module axil_reg_responder #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int NUM_REGS = 4
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESET,
  axil_reg_responder_if.slave      s_axi,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      wr_pulse
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  typedef enum logic [1:0] {W_ACCEPT, W_COMMIT, W_RESP} w_state_t;
  w_state_t      w_state;
  logic          aw_held, w_held;
  logic [AW-1:0] aw_addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   regs [NUM_REGS];
  logic          aw_hs, w_hs, ar_hs, w_err, r_err, unused;
  logic [RW-1:0] w_idx, r_idx;
  assign s_axi.S_AXI_AWREADY = !S_AXI_ARESET && w_state == W_ACCEPT && !aw_held;
  assign s_axi.S_AXI_WREADY  = !S_AXI_ARESET && w_state == W_ACCEPT && !w_held;
  assign s_axi.S_AXI_ARREADY = !S_AXI_ARESET && !s_axi.S_AXI_RVALID;
  assign aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs  = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
  assign ar_hs = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
  // low index bits select the word, so out-of-range indices alias modulo NUM_REGS
  assign w_idx = aw_addr_q[RW+1:2];
  assign r_idx = s_axi.S_AXI_ARADDR[RW+1:2];
`ifdef AXIL_REG_RESPONDER_SLVERR_EN
  assign w_err = 32'(aw_addr_q[AW-1:2]) >= NUM_REGS;
  assign r_err = 32'(s_axi.S_AXI_ARADDR[AW-1:2]) >= NUM_REGS;
`else
  assign w_err = 1'b0;
  assign r_err = 1'b0;
`endif
  assign wr_pulse = (w_state == W_COMMIT && !w_err) ? NUM_REGS'(1) << w_idx : '0;
  assign unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, aw_addr_q, s_axi.S_AXI_ARADDR};
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_q[32*i +: 32] = regs[i];
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state <= W_ACCEPT;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      s_axi.S_AXI_BVALID <= 1'b0;
      s_axi.S_AXI_BRESP <= 2'b00;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (w_state)
        W_ACCEPT: begin
          if (aw_hs) begin
            aw_held <= 1'b1;
            aw_addr_q <= s_axi.S_AXI_AWADDR;
          end
          if (w_hs) begin
            w_held <= 1'b1;
            wdata_q <= s_axi.S_AXI_WDATA;
            wstrb_q <= s_axi.S_AXI_WSTRB;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs)) w_state <= W_COMMIT;
        end
        W_COMMIT: begin
          for (int b = 0; b < 4; b++)
            if (wstrb_q[b] && !w_err) regs[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
          s_axi.S_AXI_BVALID <= 1'b1;
          s_axi.S_AXI_BRESP <= w_err ? 2'b10 : 2'b00;
          w_state <= W_RESP;
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            s_axi.S_AXI_BVALID <= 1'b0;
            aw_held <= 1'b0;
            w_held <= 1'b0;
            w_state <= W_ACCEPT;
          end
        end
        default: w_state <= W_ACCEPT;
      endcase
    end
  end
  // reads sample regs before this edge's commit, so a same-edge collision returns the old value
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      s_axi.S_AXI_RVALID <= 1'b0;
      s_axi.S_AXI_RDATA <= '0;
      s_axi.S_AXI_RRESP <= 2'b00;
    end else if (ar_hs) begin
      s_axi.S_AXI_RVALID <= 1'b1;
      s_axi.S_AXI_RDATA <= r_err ? 32'hDEADBEEF : regs[r_idx];
      s_axi.S_AXI_RRESP <= r_err ? 2'b10 : 2'b00;
    end else if (s_axi.S_AXI_RREADY) begin
      s_axi.S_AXI_RVALID <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axil_reg_responder.sv
// tb_axil_reg_responder: randomized AXI4-Lite traffic checked against a word-array model of the register bank.
module tb_axil_reg_responder;
  localparam int NR = 4;
  logic tb_ACLK = 1'b0;
  logic tb_ARESET = 1'b1;
  logic [NR*32-1:0] reg_q;
  logic [NR-1:0] wr_pulse;
  logic [31:0] model [NR];
  logic [NR-1:0] exp_pulse = '0;
  int tests = 0;
  int fails = 0;
  axil_reg_responder_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus();
  axil_reg_responder #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5), .NUM_REGS(NR)) dut (
    .S_AXI_ACLK(tb_ACLK), .S_AXI_ARESET(tb_ARESET), .s_axi(bus), .reg_q(reg_q), .wr_pulse(wr_pulse)
  );
  always #5 tb_ACLK = ~tb_ACLK;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int i = 0; i < NR; i++) f[32*i +: 32] = model[i];
    return f;
  endfunction
  function automatic bit addr_err(input logic [4:0] a);
`ifdef AXIL_REG_RESPONDER_SLVERR_EN
    return int'(a >> 2) >= NR;
`else
    return 1'b0;
`endif
  endfunction
  function automatic int idx_of(input logic [4:0] a);
    return int'(a >> 2) % NR;
  endfunction
  // every cycle: exported registers match the model, commit strobe matches the expected pulse
  always @(negedge tb_ACLK) begin
    chk("reg_q", reg_q, model_flat());
    chk("wr_pulse", 128'(wr_pulse), 128'(exp_pulse));
  end
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] st,
                    input int awd, input int wd, input int bd, input bit hold_pair);
    bit aw_done, w_done, awr, wrr, err;
    int cyc, ix;
    logic [1:0] er;
    aw_done = 0; w_done = 0; cyc = 0;
    err = addr_err(a); ix = idx_of(a); er = err ? 2'b10 : 2'b00;
    bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = st; bus.S_AXI_AWPROT = 3'($urandom);
    while (!(aw_done && w_done)) begin
      if (cyc == 40) begin
        tests++; fails++;
        $display("FAIL wr_handshake_timeout: got no handshake required handshake at %0t", $time);
        bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
        return;
      end
      bus.S_AXI_AWVALID = !aw_done && cyc >= awd;
      bus.S_AXI_WVALID = !w_done && cyc >= wd;
      @(negedge tb_ACLK);
      chk("awready", 128'(bus.S_AXI_AWREADY), 128'(!aw_done));
      chk("wready", 128'(bus.S_AXI_WREADY), 128'(!w_done));
      awr = bus.S_AXI_AWREADY; wrr = bus.S_AXI_WREADY;
      @(posedge tb_ACLK);
      if (bus.S_AXI_AWVALID && awr) aw_done = 1;
      if (bus.S_AXI_WVALID && wrr) w_done = 1;
      #1 cyc++;
    end
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0;
    exp_pulse = err ? '0 : NR'(1) << ix;
    @(negedge tb_ACLK);
    chk("bvalid_early", 128'(bus.S_AXI_BVALID), 0);
    @(posedge tb_ACLK);
    if (!err) for (int b = 0; b < 4; b++) if (st[b]) model[ix][8*b +: 8] = d[8*b +: 8];
    exp_pulse = '0;
    #1;
    for (int i = 0; i < bd; i++) begin
      bus.S_AXI_AWVALID = hold_pair; bus.S_AXI_WVALID = hold_pair;
      @(negedge tb_ACLK);
      chk("bvalid_hold", 128'(bus.S_AXI_BVALID), 1);
      chk("bresp_hold", 128'(bus.S_AXI_BRESP), 128'(er));
      chk("awready_busy", 128'(bus.S_AXI_AWREADY), 0);
      chk("wready_busy", 128'(bus.S_AXI_WREADY), 0);
      @(posedge tb_ACLK);
      #1;
    end
    bus.S_AXI_AWVALID = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_BREADY = 1;
    @(negedge tb_ACLK);
    chk("bvalid", 128'(bus.S_AXI_BVALID), 1);
    chk("bresp", 128'(bus.S_AXI_BRESP), 128'(er));
    @(posedge tb_ACLK);
    #1 bus.S_AXI_BREADY = 0;
  endtask
  task automatic rd(input logic [4:0] a, input int ard, input int rrd, output logic [31:0] got);
    logic [31:0] ed;
    logic [1:0] er;
    repeat (ard) begin
      @(posedge tb_ACLK);
      #1;
    end
    bus.S_AXI_ARADDR = a; bus.S_AXI_ARPROT = 3'($urandom); bus.S_AXI_ARVALID = 1;
    @(negedge tb_ACLK);
    chk("arready", 128'(bus.S_AXI_ARREADY), 1);
    // model as of before the coming edge: a commit on that same edge must not be visible
    ed = addr_err(a) ? 32'hDEADBEEF : model[idx_of(a)];
    er = addr_err(a) ? 2'b10 : 2'b00;
    @(posedge tb_ACLK);
    #1 bus.S_AXI_ARVALID = 0;
    for (int i = 0; i < rrd; i++) begin
      @(negedge tb_ACLK);
      chk("rvalid_hold", 128'(bus.S_AXI_RVALID), 1);
      chk("rdata_hold", 128'(bus.S_AXI_RDATA), 128'(ed));
      chk("rresp_hold", 128'(bus.S_AXI_RRESP), 128'(er));
      chk("arready_busy", 128'(bus.S_AXI_ARREADY), 0);
      @(posedge tb_ACLK);
      #1;
    end
    bus.S_AXI_RREADY = 1;
    @(negedge tb_ACLK);
    chk("rvalid", 128'(bus.S_AXI_RVALID), 1);
    chk("rdata", 128'(bus.S_AXI_RDATA), 128'(ed));
    chk("rresp", 128'(bus.S_AXI_RRESP), 128'(er));
    got = bus.S_AXI_RDATA;
    @(posedge tb_ACLK);
    #1 bus.S_AXI_RREADY = 0;
    @(negedge tb_ACLK);
    chk("rvalid_clear", 128'(bus.S_AXI_RVALID), 0);
    @(posedge tb_ACLK);
    #1;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: got no finish required finish by %0t", $time);
    $fatal(1);
  end
  initial begin
    logic [31:0] d;
    for (int i = 0; i < NR; i++) model[i] = '0;
    bus.S_AXI_AWADDR = 0; bus.S_AXI_AWPROT = 0; bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WDATA = 0; bus.S_AXI_WSTRB = 0; bus.S_AXI_WVALID = 0; bus.S_AXI_BREADY = 0;
    bus.S_AXI_ARADDR = 0; bus.S_AXI_ARPROT = 0; bus.S_AXI_ARVALID = 0; bus.S_AXI_RREADY = 0;
    repeat (2) @(posedge tb_ACLK);
    @(negedge tb_ACLK);
    chk("rst_awready", 128'(bus.S_AXI_AWREADY), 0);
    chk("rst_wready", 128'(bus.S_AXI_WREADY), 0);
    chk("rst_arready", 128'(bus.S_AXI_ARREADY), 0);
    chk("rst_bvalid", 128'(bus.S_AXI_BVALID), 0);
    chk("rst_rvalid", 128'(bus.S_AXI_RVALID), 0);
    chk("rst_resp", 128'({bus.S_AXI_BRESP, bus.S_AXI_RRESP}), 0);
    chk("rst_rdata", 128'(bus.S_AXI_RDATA), 0);
    chk("rst_reg_q", reg_q, 0);
    @(posedge tb_ACLK);
    #1 tb_ARESET = 0;
    wr(5'h00, 32'h0101FFFF, 4'hF, 0, 0, 0, 0); rd(5'h00, 0, 0, d); chk("lit_rb0", 128'(d), 128'h0101FFFF);
    wr(5'h04, 32'hABCD0001, 4'hF, 1, 0, 1, 0); rd(5'h04, 0, 1, d); chk("lit_rb1", 128'(d), 128'hABCD0001);
    wr(5'h08, 32'hDEAD0011, 4'hF, 0, 1, 0, 0); rd(5'h08, 1, 0, d); chk("lit_rb2", 128'(d), 128'hDEAD0011);
    wr(5'h0C, 32'hBEEF0011, 4'hF, 0, 0, 2, 0); rd(5'h0C, 0, 2, d); chk("lit_rb3", 128'(d), 128'hBEEF0011);
    chk("lit_reg_q_w3", 128'(reg_q[127:96]), 128'hBEEF0011);
    wr(5'h04, 32'h12345678, 4'hF, 0, 3, 0, 0); rd(5'h04, 0, 0, d); chk("lit_aw_first", 128'(d), 128'h12345678);
    wr(5'h00, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 0); rd(5'h00, 0, 0, d); chk("lit_strb", 128'(d), 128'h01BBFFDD);
    wr(5'h08, 32'hCAFEF00D, 4'hF, 0, 0, 5, 1); rd(5'h08, 0, 0, d); chk("lit_bstall", 128'(d), 128'hCAFEF00D);
    wr(5'h10, 32'h00000055, 4'hF, 0, 0, 0, 0);
`ifdef AXIL_REG_RESPONDER_SLVERR_EN
    chk("lit_oor_word0", 128'(reg_q[31:0]), 128'h01BBFFDD);
    rd(5'h10, 0, 0, d); chk("lit_oor_rd", 128'(d), 128'hDEADBEEF);
`else
    chk("lit_oor_word0", 128'(reg_q[31:0]), 128'h00000055);
    rd(5'h10, 0, 0, d); chk("lit_oor_rd", 128'(d), 128'h00000055);
`endif
    fork
      for (int k = 0; k < 40; k++)
        wr(5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      begin
        logic [31:0] dd;
        for (int k = 0; k < 40; k++)
          rd(5'($urandom_range(0, 31)), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), dd);
      end
    join
    bus.S_AXI_ARADDR = 5'h04; bus.S_AXI_ARVALID = 1;
    @(posedge tb_ACLK);
    #1 bus.S_AXI_ARVALID = 0;
    tb_ARESET = 1;
    @(negedge tb_ACLK);
    chk("rvalid_pre_rst", 128'(bus.S_AXI_RVALID), 1);
    @(posedge tb_ACLK);
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(negedge tb_ACLK);
    chk("rst_mid_rvalid", 128'(bus.S_AXI_RVALID), 0);
    chk("rst_mid_reg_q", reg_q, 0);
    chk("rst_mid_arready", 128'(bus.S_AXI_ARREADY), 0);
    chk("rst_mid_rdata", 128'(bus.S_AXI_RDATA), 0);
    @(posedge tb_ACLK);
    #1 tb_ARESET = 0;
    @(negedge tb_ACLK);
    chk("post_rst_arready", 128'(bus.S_AXI_ARREADY), 1);
    chk("post_rst_awready", 128'(bus.S_AXI_AWREADY), 1);
    chk("post_rst_bvalid", 128'(bus.S_AXI_BVALID), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axil_reg_responder.md
Name: axil_reg_responder

Overview:
- AXI4-Lite slave (responder) register bank; the target end of the lite-master write/read bursts issued by the BFM benches.
- Holds NUM_REGS 32-bit control words, exported flat to downstream fabric (PWM, GPIO config).
- Sits behind the interconnect on an ACLK domain.
- Independent write (AW/W/B) and read (AR/R) engines; one outstanding transaction each.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; word index = addr[ADDR_WIDTH-1:2].
- NUM_REGS, 4, implemented words; must be ≤ 2^(ADDR_WIDTH-2).

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESET  in  1  reset; synchronous, active-high.
- S_AXI_AWADDR  in  ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake.
- S_AXI_ARADDR  in  ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake.
- reg_q  out  NUM_REGS*32  register contents; word i at [32i+31:32i].
- wr_pulse  out  NUM_REGS  one-cycle strobe on commit to word i.

Behaviour:
- Reset (S_AXI_ARESET high at a clock edge):
  - All regs 0; aw_held/w_held cleared.
  - BVALID, RVALID, BRESP, RRESP, RDATA, wr_pulse = 0.
  - AWREADY, WREADY, ARREADY = 0 while reset is high.
  - Readies may assert from the first cycle after reset is sampled low.
- Reset mid-transaction: all pending/held state is discarded; no B/R response is issued.
- Write engine, states W_ACCEPT, W_COMMIT, W_RESP:
  - W_ACCEPT:
    - AWREADY = !aw_held; WREADY = !w_held.
    - AW and W may arrive in any order or in the same cycle; each is latched on its own handshake.
    - Once both are held (including the edge both handshake together) -> W_COMMIT.
  - W_COMMIT (1 cycle):
    - Byte lanes with WSTRB[b]=1 update the addressed word; wr_pulse[idx]=1 for that cycle, even when WSTRB=0.
    - BVALID=1 and BRESP=OKAY (00) on the following edge -> W_RESP.
  - W_RESP: BVALID and BRESP are held stable until BREADY=1; then BVALID=0, held flags cleared -> W_ACCEPT. AWREADY/WREADY are low throughout.
  - Latency: last of the AW/W handshakes at edge N -> register and reg_q updated at N+1 -> BVALID high after N+1.
  - BREADY held high gives one write every 3 cycles.
- Read engine:
  - ARREADY = !RVALID.
  - AR handshake at edge N: RDATA = word[idx], RRESP=OKAY, RVALID=1 from edge N.
  - RDATA/RRESP are stable while RVALID && !RREADY.
  - RREADY=1 clears RVALID at the next edge; back-to-back reads complete every 2 cycles.
- Same-word collision: a read handshake on the same edge as a W_COMMIT returns the pre-write value.
- Address:
  - Low two bits are ignored.
  - Index ≥ NUM_REGS without the optional feature: the index wraps modulo NUM_REGS (power-of-two NUM_REGS), and the response is OKAY.
- AWPROT/ARPROT are ignored; EXOKAY is never generated.

Optional Feature:
- Macro AXIL_REG_RESPONDER_SLVERR_EN.
- Defined:
  - Index ≥ NUM_REGS returns SLVERR (2'b10).
  - Writes are dropped: no register change, no wr_pulse.
  - Reads return RDATA=0xDEADBEEF.
- Undefined: the modulo-aliasing rule applies and all responses are OKAY.

Test Plan:
- Write 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011 to addresses 0x0/0x4/0x8/0xC, reading each back:
  - BRESP=RRESP=00 throughout.
  - Readback equals the written data.
  - reg_q[127:96]=0xBEEF0011.
- AW presented 3 cycles before W to addr 0x4, data 0x12345678:
  - AWREADY drops after the AW handshake.
  - BVALID rises 1 cycle after the W handshake.
  - wr_pulse=4'b0010 for exactly 1 cycle.
- Word 0=0x0101FFFF, then write 0xAABBCCDD with WSTRB=4'b0101 -> readback 0x01BBFFDD.
- BREADY held low 5 cycles:
  - BVALID stays high and BRESP is stable.
  - AWREADY/WREADY stay 0.
  - A second AW/W pair is not accepted until the B handshake.
- Write addr 0x10, data 0x55:
  - Macro undefined: BRESP=00 and word 0=0x55.
  - Macro defined: BRESP=10, no word changes, and a read of 0x10 gives RRESP=10, RDATA=0xDEADBEEF.
- Reset asserted while RVALID=1 and RREADY=0:
  - The next cycle shows RVALID=0 and all reg_q=0.
  - ARREADY is 1 once reset is low.
